nibble_serial_add_ctrl: RTL and testbench

//  Sequencer that adds two WIDTH-bit operands on one shared external 4-bit adder

---
 rtl/nibble_serial_add_ctrl.sv | 93 +++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: drives one external 4-bit adder slice, LSB nibble first,
// with the carry registered between nibbles and a start/busy/done handshake.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        // DONE doubles as an accept slot so back-to-back adds issue every NIB+1 cycles.
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum_q[{idx_q, 2'b00} +: 4] <= add_sum;
          carry_q                    <= add_cout;
          idx_q                      <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_q  <= add_cout;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slice inputs come from registers only and are parked at zero outside RUN.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_a   = a_q[{idx_q, 2'b00} +: 4];
      add_b   = b_q[{idx_q, 2'b00} +: 4];
      add_cin = carry_q;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: a 16-bit and an 8-bit instance, each wired
// to a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        s_start, s_cin, s_busy, s_done, s_cout;
  logic [15:0] s_a, s_b, s_sum;
  logic [3:0]  s_add_a, s_add_b, s_add_sum;
  logic        s_add_cin, s_add_cout;
  assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'd0, s_add_cin};

  // 8-bit instance
  logic        e_start, e_cin, e_busy, e_done, e_cout;
  logic [7:0]  e_a, e_b, e_sum;
  logic [3:0]  e_add_a, e_add_b, e_add_sum;
  logic        e_add_cin, e_add_cout;
  assign {e_add_cout, e_add_sum} = {1'b0, e_add_a} + {1'b0, e_add_b} + {4'd0, e_add_cin};

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
    .add_sum(s_add_sum), .add_cout(s_add_cout)
  );

  nibble_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(e_start), .a(e_a), .b(e_b), .cin(e_cin),
    .busy(e_busy), .done(e_done), .sum(e_sum), .cout(e_cout),
    .add_a(e_add_a), .add_b(e_add_b), .add_cin(e_add_cin),
    .add_sum(e_add_sum), .add_cout(e_add_cout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp16_q[$];
  logic [8:0]  exp8_q[$];

  task automatic test_reset();
    rst_n   = 1'b0;
    s_start = 1'b1;
    s_a     = 16'hA5A5;
    s_b     = 16'h5A5A;
    s_cin   = 1'b1;
    e_start = 1'b1;
    e_a     = 8'h3C;
    e_b     = 8'hC3;
    e_cin   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_busy, s_done, s_cout, s_sum} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs16: busy=%b done=%b cout=%b sum=%h, want all 0",
               s_busy, s_done, s_cout, s_sum);
    end
    n_checks++;
    if ({s_add_a, s_add_b, s_add_cin} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_slice16: add_a=%h add_b=%h add_cin=%b, want 0", s_add_a, s_add_b,
               s_add_cin);
    end
    n_checks++;
    if ({e_busy, e_done, e_cout, e_sum, e_add_a, e_add_b, e_add_cin} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs8: busy=%b done=%b sum=%h add_a=%h, want all 0",
               e_busy, e_done, e_sum, e_add_a);
    end
    s_start = 1'b0;
    e_start = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_busy !== 1'b0 || e_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy16=%b busy8=%b, want 0 0", s_busy, e_busy);
    end
  endtask

  // Test 1: zero operands, done seen on the 5th falling edge after driving start.
  task automatic test_zero_latency();
    int cyc;
    bit got;
    logic [16:0] exp;
    s_a = 16'h0000;
    s_b = 16'h0000;
    s_cin = 1'b0;
    s_start = 1'b1;
    exp16_q.push_back(17'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      s_start = 1'b0;
      cyc++;
      if (s_done) got = 1'b1;
    end
    n_checks++;
    if (!got || cyc != 5) begin
      n_fail++;
      $display("FAIL zero_latency: done seen=%b after %0d cycles, want 1 after 5", got, cyc);
    end
    exp = exp16_q.size() > 0 ? exp16_q.pop_front() : 17'h1FFFF;
    n_checks++;
    if ({s_cout, s_sum} !== exp) begin
      n_fail++;
      $display("FAIL zero_result: {cout,sum}=%h, want %h", {s_cout, s_sum}, exp);
    end
    @(negedge clk);
    n_checks++;
    if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse_width: done=%b busy=%b after pulse, want 0 0", s_done, s_busy);
    end
  endtask

  // One add with the slice inputs traced nibble by nibble against a ripple model.
  task automatic test_traced(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic cin);
    logic [3:0]  exp_cin;
    logic        c;
    logic [4:0]  t;
    logic [16:0] exp;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      exp_cin[i] = c;
      t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      c = t[4];
    end
    s_a = a;
    s_b = b;
    s_cin = cin;
    s_start = 1'b1;
    exp16_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_start = 1'b0;
      s_a = ~a;
      s_b = ~b;
      s_cin = ~cin;
      n_checks++;
      if ({s_busy, s_done, s_add_a, s_add_b, s_add_cin} !==
          {1'b1, 1'b0, a[4*i +: 4], b[4*i +: 4], exp_cin[i]}) begin
        n_fail++;
        $display("FAIL %s_nibble%0d: busy=%b done=%b add_a=%h add_b=%h add_cin=%b, want 1 0 %h %h %b",
                 name, i, s_busy, s_done, s_add_a, s_add_b, s_add_cin, a[4*i +: 4],
                 b[4*i +: 4], exp_cin[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (s_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done=%b, want 1", name, s_done);
    end
    exp = exp16_q.size() > 0 ? exp16_q.pop_front() : 17'h1FFFF;
    n_checks++;
    if ({s_cout, s_sum} !== exp) begin
      n_fail++;
      $display("FAIL %s_result: {cout,sum}=%h, want %h", name, {s_cout, s_sum}, exp);
    end
    n_checks++;
    if ({s_add_a, s_add_b, s_add_cin} !== 9'd0) begin
      n_fail++;
      $display("FAIL %s_slice_idle: add_a=%h add_b=%h add_cin=%b, want 0", name, s_add_a,
               s_add_b, s_add_cin);
    end
    @(negedge clk);
    n_checks++;
    if ({s_done, s_busy, s_cout, s_sum} !== {2'b00, exp}) begin
      n_fail++;
      $display("FAIL %s_hold: done=%b busy=%b {cout,sum}=%h, want 0 0 %h", name, s_done,
               s_busy, {s_cout, s_sum}, exp);
    end
  endtask

  // Test 4: start held high with new operands every cycle; accepts land every 5 cycles.
  task automatic test_back_to_back();
    int n_done;
    logic [16:0] exp;
    n_done = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        n_checks++;
        if (s_done !== (k % 5 == 0 && k <= 15)) begin
          n_fail++;
          $display("FAIL b2b_done_k%0d: done=%b, want %b", k, s_done, (k % 5 == 0 && k <= 15));
        end
        if (k <= 15) begin
          n_checks++;
          if (s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_k%0d: busy=%b, want 1", k, s_busy);
          end
        end
        if (s_done) begin
          n_done++;
          exp = exp16_q.size() > 0 ? exp16_q.pop_front() : 17'h1FFFF;
          n_checks++;
          if ({s_cout, s_sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result_k%0d: {cout,sum}=%h, want %h", k, {s_cout, s_sum}, exp);
          end
        end
      end
      if (k <= 10) begin
        s_start = 1'b1;
        s_a = 16'($urandom);
        s_b = 16'($urandom);
        s_cin = 1'($urandom);
        if (k % 5 == 0) exp16_q.push_back({1'b0, s_a} + {1'b0, s_b} + {16'd0, s_cin});
      end else begin
        s_start = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_done != 3 || exp16_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d left=%0d, want 3 0", n_done, exp16_q.size());
    end
  endtask

  // Test 5: asynchronous reset in the second RUN cycle discards the add.
  task automatic test_reset_mid_run();
    int spurious;
    s_a = 16'h1234;
    s_b = 16'h1111;
    s_cin = 1'b0;
    s_start = 1'b1;
    exp16_q.push_back({1'b0, s_a} + {1'b0, s_b});
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_sum[3:0] !== 4'h5 || s_add_a !== 4'h3) begin
      n_fail++;
      $display("FAIL midrun_partial: sum[3:0]=%h add_a=%h, want 5 3", s_sum[3:0], s_add_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_busy, s_done, s_cout, s_sum, s_add_a, s_add_b, s_add_cin} !== 28'd0) begin
      n_fail++;
      $display("FAIL midrun_async_clear: busy=%b done=%b sum=%h add_a=%h, want all 0",
               s_busy, s_done, s_sum, s_add_a);
    end
    exp16_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_done || s_busy) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: %0d cycles busy/done after reset, want 0", spurious);
    end
    test_traced("after_reset", 16'hBEEF, 16'h4321, 1'b1);
  endtask

  // Test 6: WIDTH=8 sweep, every a with 33 b values and both cin; adds issue back to back.
  task automatic test_w8_sweep();
    int cyc;
    bit got;
    logic [7:0]  bv;
    logic [8:0]  exp;
    for (int ai = 0; ai < 256; ai++) begin
      for (int j = 0; j <= 32; j++) begin
        for (int ci = 0; ci < 2; ci++) begin
          bv = (j == 32) ? 8'hFF : 8'((j * 8 + ai) & 255);
          e_a = 8'(ai);
          e_b = bv;
          e_cin = 1'(ci);
          e_start = 1'b1;
          exp8_q.push_back({1'b0, e_a} + {1'b0, e_b} + {8'd0, e_cin});
          cyc = 0;
          got = 1'b0;
          while (!got && cyc < 10) begin
            @(negedge clk);
            e_start = 1'b0;
            cyc++;
            if (e_done) got = 1'b1;
          end
          exp = exp8_q.size() > 0 ? exp8_q.pop_front() : 9'h1FF;
          n_checks++;
          if (!got || cyc != 3 || {e_cout, e_sum} !== exp) begin
            n_fail++;
            $display("FAIL w8_add a=%h b=%h cin=%0d: done=%b cyc=%0d {cout,sum}=%h, want 1 3 %h",
                     8'(ai), bv, ci, got, cyc, {e_cout, e_sum}, exp);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    s_start = 1'b0;
    s_a = '0;
    s_b = '0;
    s_cin = 1'b0;
    e_start = 1'b0;
    e_a = '0;
    e_b = '0;
    e_cin = 1'b0;
    test_reset();
    test_zero_latency();
    test_traced("ripple", 16'hFFFF, 16'h0001, 1'b0);
    test_traced("cin_only", 16'h0FFF, 16'h0000, 1'b1);
    test_traced("mixed", 16'h9C3A, 16'h67D5, 1'b1);
    test_back_to_back();
    test_reset_mid_run();
    test_w8_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
